// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern Avalon-MM master.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT
  } state_e;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_WALK   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [3:0] PIO_BYTEEN = 4'b0001;
  localparam logic [7:0] PAT_RESET  = 8'h01;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/led_pattern_next.sv
// Combinational next-pattern / next-direction logic for the LED sequencer.
module led_pattern_next
  import led_pattern_pkg::*;
(
  input  logic [7:0] pattern_i,
  input  dir_e       dir_i,
  input  logic [1:0] mode_i,
  output logic [7:0] pattern_o,
  output dir_e       dir_o
);

  logic onehot;
  assign onehot = is_onehot8(pattern_i);

  always_comb begin
    pattern_o = pattern_i;
    dir_o     = dir_i;
    case (mode_e'(mode_i))
      MODE_COUNT: pattern_o = pattern_i + 8'd1;
      MODE_WALK: begin
        if (!onehot) begin
          pattern_o = PAT_RESET;
          dir_o     = DIR_LEFT;
        end else begin
          pattern_o = {pattern_i[6:0], pattern_i[7]};
        end
      end
      MODE_BOUNCE: begin
        // End stops take priority over the stored direction so a stale
        // direction left over from another mode cannot fall off the edge.
        if (!onehot) begin
          pattern_o = PAT_RESET;
          dir_o     = DIR_LEFT;
        end else if (pattern_i == 8'h80) begin
          pattern_o = 8'h40;
          dir_o     = DIR_RIGHT;
        end else if (pattern_i == 8'h01) begin
          pattern_o = 8'h02;
          dir_o     = DIR_LEFT;
        end else if (dir_i == DIR_LEFT) begin
          pattern_o = {pattern_i[6:0], 1'b0};
        end else begin
          pattern_o = {1'b0, pattern_i[7:1]};
        end
      end
      MODE_HOLD: pattern_o = pattern_i;
      default:   pattern_o = pattern_i;
    endcase
  end

endmodule

// File: rtl/led_pattern_master.sv
// Avalon-MM master that steps an 8-bit LED pattern into a PIO data register.
// Optional readback verification of every write: define LED_PATTERN_READBACK_EN.
//
// state        | meaning
// ST_IDLE      | sequencer stopped, no bus activity
// ST_WAIT_TICK | counting clock cycles to the next pattern step
// ST_WRITE     | write command held until waitrequest drops
// ST_READ      | readback command held until waitrequest drops
// ST_READ_WAIT | waiting for readdatavalid, then compare
module led_pattern_master
  import led_pattern_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TARGET_ADDR = '0,
  parameter int                TICK_DIV    = 50000000,
  parameter int                CNT_W       = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [7:0]        pattern,
  output logic              mismatch,
  output logic [15:0]       err_count
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pattern_q, pattern_d;
  dir_e             dir_q, dir_d;
  logic             write_q, write_d;
  logic             read_q, read_d;
  logic             mismatch_q, mismatch_d;
  logic [15:0]      err_q, err_d;

  logic [7:0] pat_nxt;
  dir_e       dir_nxt;

  led_pattern_next u_next (
    .pattern_i (pattern_q),
    .dir_i     (dir_q),
    .mode_i    (mode),
    .pattern_o (pat_nxt),
    .dir_o     (dir_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    write_d    = write_q;
    read_d     = read_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT_TICK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TICK_LAST) begin
          cnt_d     = '0;
          pattern_d = pat_nxt;
          dir_d     = dir_nxt;
          write_d   = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        // A command is only released once the slave has accepted it.
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          if (!enable) begin
            state_d = ST_IDLE;
          end else begin
`ifdef LED_PATTERN_READBACK_EN
            read_d  = 1'b1;
            state_d = ST_READ;
`else
            state_d = ST_WAIT_TICK;
`endif
          end
        end
      end
`ifdef LED_PATTERN_READBACK_EN
      ST_READ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[7:0] != pattern_q) begin
            mismatch_d = 1'b1;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pattern_q  <= PAT_RESET;
      dir_q      <= DIR_LEFT;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      write_q    <= write_d;
      read_q     <= read_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign avm_address    = TARGET_ADDR;
  assign avm_byteenable = PIO_BYTEEN;
  assign avm_writedata  = {24'h0, pattern_q};
  assign avm_write      = write_q;
  assign pattern        = pattern_q;

  // Without readback the read/compare flops never leave their reset value.
  assign avm_read  = read_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

  logic unused_rd;
`ifdef LED_PATTERN_READBACK_EN
  assign unused_rd = ^avm_readdata[31:8];
`else
  assign unused_rd = ^{avm_readdata, avm_readdatavalid};
`endif

endmodule

// File: tb/tb_led_pattern_master.sv
// Directed, table-driven bench for led_pattern_master (TICK_DIV=4).
module tb_led_pattern_master;
  localparam int          TICK_DIV = 4;
  localparam int          CNT_W    = 3;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] TARGET   = 32'h0000_0040;
`ifdef LED_PATTERN_READBACK_EN
  localparam int   PERIOD   = TICK_DIV + 3;
  localparam logic EXP_READ = 1'b1;
`else
  localparam int   PERIOD   = TICK_DIV + 1;
  localparam logic EXP_READ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable;
  logic [1:0] mode;
  logic [ADDR_W-1:0] avm_address;
  logic avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [3:0] avm_byteenable;
  logic avm_waitrequest;
  logic [31:0] avm_readdata = 32'h0;
  logic avm_readdatavalid = 1'b0;
  logic [7:0] pattern;
  logic mismatch;
  logic [15:0] err_count;

  led_pattern_master #(
    .ADDR_W(ADDR_W), .TARGET_ADDR(TARGET), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .pattern(pattern),
    .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0, tmo = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model / monitor: inputs change on negedge, observed 1 unit later.
  int wcount = 0, rcount = 0, wstamp = 0;
  logic [7:0] wlast = 8'h00, echo = 8'h00, rd_ovr = 8'h00;
  logic rd_ovr_en = 1'b0, rd_pend = 1'b0, saw_read = 1'b0;
  always @(negedge clk) begin
    #1;
    avm_readdatavalid = rd_pend;
    avm_readdata      = rd_pend ? {24'h0, (rd_ovr_en ? rd_ovr : echo)} : 32'h0;
    rd_pend = 1'b0;
    if (avm_read) saw_read = 1'b1;
    if (avm_write && !avm_waitrequest) begin
      wcount++;
      wlast  = avm_writedata[7:0];
      echo   = wlast;
      wstamp = cyc;
    end
    if (avm_read && !avm_waitrequest) begin
      rcount++;
      rd_pend = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_tmo(input string name);
    tests++;
    failed++;
    tmo++;
    $display("FAIL %s: timed out waiting for bus event", name);
  endtask

  task automatic wait_write(input string name, output logic [7:0] data, output int stamp);
    int start = wcount;
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (wcount != start) begin got = 1; break; end
    end
    if (!got) fail_tmo(name);
    data  = wlast;
    stamp = wstamp;
  endtask

  task automatic wait_read(input string name);
    int start = rcount;
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (rcount != start) begin got = 1; break; end
    end
    if (!got) fail_tmo(name);
  endtask

  task automatic wait_wr_assert(input string name);
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (avm_write) begin got = 1; break; end
    end
    if (!got) fail_tmo(name);
  endtask

  // Call right after a write was seen; returns at a negedge with no command pending.
  task automatic quiet();
`ifdef LED_PATTERN_READBACK_EN
    wait_read("quiet_read");
`endif
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [35];

  logic [7:0] d;
  int st, pst, c0, r0;
  logic [31:0] wd0;
  bit bad, found;

  initial begin
    vecs = '{
      '{2'b00, 8'h02}, '{2'b00, 8'h03}, '{2'b00, 8'h04}, '{2'b01, 8'h08}, '{2'b01, 8'h10},
      '{2'b11, 8'h10}, '{2'b00, 8'h11}, '{2'b01, 8'h01},
      '{2'b10, 8'h02}, '{2'b10, 8'h04}, '{2'b10, 8'h08}, '{2'b10, 8'h10}, '{2'b10, 8'h20},
      '{2'b10, 8'h40}, '{2'b10, 8'h80}, '{2'b10, 8'h40}, '{2'b10, 8'h20}, '{2'b10, 8'h10},
      '{2'b10, 8'h08}, '{2'b10, 8'h04}, '{2'b10, 8'h02}, '{2'b10, 8'h01}, '{2'b10, 8'h02},
      '{2'b10, 8'h04}, '{2'b11, 8'h04}, '{2'b00, 8'h05}, '{2'b10, 8'h01}, '{2'b10, 8'h02},
      '{2'b01, 8'h04}, '{2'b01, 8'h08}, '{2'b01, 8'h10}, '{2'b01, 8'h20}, '{2'b01, 8'h40},
      '{2'b01, 8'h80}, '{2'b01, 8'h01}
    };
    reset = 1'b1; enable = 1'b0; mode = 2'b00; avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_pattern", pattern, 8'h01);
    check("rst_write", avm_write, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_mismatch", mismatch, 1'b0);
    check("rst_err_count", err_count, 16'h0);
    check("rst_writedata", avm_writedata, 32'h0000_0001);

    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    pst = 0;
    for (int k = 0; k < 35; k++) begin
      mode = vecs[k].mode;
      wait_write($sformatf("vec%0d_wait", k), d, st);
      if (tmo != 0) break;
      check($sformatf("vec%0d_data", k), d, vecs[k].exp);
      check($sformatf("vec%0d_pattern", k), pattern, vecs[k].exp);
      check($sformatf("vec%0d_addr", k), avm_address, TARGET);
      check($sformatf("vec%0d_byteen", k), avm_byteenable, 4'b0001);
      if (k > 0) check($sformatf("vec%0d_period", k), st - pst, PERIOD);
      pst = st;
    end

    mode = 2'b00;
    found = 0;
    for (int i = 0; i < 300 && tmo == 0; i++) begin
      wait_write("wrap_step", d, st);
      if (d == 8'hFF) begin
        wait_write("wrap_next", d, st);
        check("wrap_ff_to_00", d, 8'h00);
        found = 1;
        break;
      end
    end
    if (!found && tmo == 0) fail_tmo("wrap_reach_ff");

    // Write held under waitrequest for 5 cycles, accepted on the 6th.
    quiet();
    avm_waitrequest = 1'b1;
    c0 = wcount;
    wait_wr_assert("stall_assert");
    wd0 = avm_writedata;
    check("stall_first_data", wd0, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == 5) avm_waitrequest = 1'b0;
        #2;
      end
      check($sformatf("stall_write_c%0d", i), avm_write, 1'b1);
      check($sformatf("stall_data_c%0d", i), avm_writedata, wd0);
    end
    quiet();
    check("stall_write_drop", avm_write, 1'b0);
    check("stall_one_accept", wcount - c0, 1);

    // Enable dropped while a write is stalled.
    avm_waitrequest = 1'b1;
    c0 = wcount;
    r0 = rcount;
    wait_wr_assert("endrop_assert");
    @(negedge clk); enable = 1'b0; #2;
    check("endrop_write_held", avm_write, 1'b1);
    @(negedge clk); avm_waitrequest = 1'b0; #2;
    check("endrop_write_last", avm_write, 1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (avm_write || avm_read) bad = 1;
    end
    check("endrop_idle_quiet", bad, 1'b0);
    check("endrop_one_write", wcount - c0, 1);
    check("endrop_no_read", rcount - r0, 0);
    check("endrop_held_pattern", pattern, 8'h02);
    @(negedge clk); enable = 1'b1;
    wait_write("resume", d, st);
    check("resume_data", d, 8'h03);

`ifdef LED_PATTERN_READBACK_EN
    wait_write("rb_w04", d, st);
    check("rb_w04_data", d, 8'h04);
    wait_read("rb_r04");
    repeat (2) @(negedge clk);
    #2;
    check("rb_clean_mismatch", mismatch, 1'b0);
    check("rb_clean_err", err_count, 16'h0);
    rd_ovr = 8'h00; rd_ovr_en = 1'b1;
    wait_write("rb_w05", d, st);
    check("rb_w05_data", d, 8'h05);
    wait_read("rb_r05");
    repeat (2) @(negedge clk);
    #2;
    check("rb_bad_mismatch", mismatch, 1'b1);
    check("rb_bad_err", err_count, 16'h1);
    rd_ovr_en = 1'b0;
    wait_write("rb_w06", d, st);
    wait_read("rb_r06");
    repeat (2) @(negedge clk);
    #2;
    check("rb_sticky_mismatch", mismatch, 1'b1);
    check("rb_sticky_err", err_count, 16'h1);
    // Reset while in READ_WAIT.
    wait_write("rst_rw_w07", d, st);
    wait_read("rst_rw_r07");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #2;
`else
    // Reset while a write is stalled.
    quiet();
    avm_waitrequest = 1'b1;
    wait_wr_assert("rst_wr_assert");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #2;
`endif
    check("midrst_write", avm_write, 1'b0);
    check("midrst_read", avm_read, 1'b0);
    check("midrst_pattern", pattern, 8'h01);
    check("midrst_mismatch", mismatch, 1'b0);
    check("midrst_err", err_count, 16'h0);
    @(negedge clk);
    avm_waitrequest = 1'b0; reset = 1'b0; mode = 2'b00;
    c0 = cyc;
    wait_write("post_reset", d, st);
    check("post_reset_data", d, 8'h02);
    check("post_reset_latency", st - c0, TICK_DIV + 1);
    check("read_activity", saw_read, EXP_READ);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
